// File: rtl/exception_sequencer.sv
// Exception sequencer: flush, vector to handler, return via epc+1, halt on nesting.
// Ports: clk, rst (sync, active-high); exception_flag/cause_ovf/pc_in/instr_in/eret in;
//   stall/flush/pc_load/pc_target/in_handler/halted control out;
//   epc/cause/bad_instr saved state; exc_count accepted-exception counter.
module exception_sequencer #(
  parameter logic [15:0] VEC_ILLEGAL = 16'h0010,
  parameter logic [15:0] VEC_OVF     = 16'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_flag,
  input  logic        cause_ovf,
  input  logic [15:0] pc_in,
  input  logic [15:0] instr_in,
  input  logic        eret,
  output logic        stall,
  output logic        flush,
  output logic        pc_load,
  output logic [15:0] pc_target,
  output logic [15:0] epc,
  output logic [1:0]  cause,
  output logic [15:0] bad_instr,
  output logic        in_handler,
  output logic        halted,
  output logic [7:0]  exc_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_VECTOR,
    S_HANDLER,
    S_RETURN,
    S_HALT
  } state_t;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_ILL  = 2'b01;
  localparam logic [1:0] C_OVF  = 2'b10;

  state_t state;
  state_t state_nxt;

  logic accept;
  assign accept = (state == S_IDLE) && exception_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      epc       <= '0;
      bad_instr <= '0;
      cause     <= C_NONE;
      exc_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        epc       <= pc_in;
        bad_instr <= instr_in;
        cause     <= cause_ovf ? C_OVF : C_ILL;
        if (exc_count != 8'hFF)
          exc_count <= exc_count + 8'd1;
      end
      if (state == S_RETURN)
        cause <= C_NONE;
    end
  end

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    flush      = 1'b0;
    pc_load    = 1'b0;
    pc_target  = '0;
    in_handler = 1'b0;
    halted     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (exception_flag)
          state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        flush     = 1'b1;
        stall     = 1'b1;
        state_nxt = S_VECTOR;
      end
      S_VECTOR: begin
        pc_load   = 1'b1;
        stall     = 1'b1;
        pc_target = (cause == C_OVF) ? VEC_OVF : VEC_ILLEGAL;
        state_nxt = S_HANDLER;
      end
      S_HANDLER: begin
        in_handler = 1'b1;
        // a nested exception outranks a simultaneous return
        if (exception_flag)
          state_nxt = S_HALT;
        else if (eret)
          state_nxt = S_RETURN;
      end
      S_RETURN: begin
        pc_load   = 1'b1;
        stall     = 1'b1;
        pc_target = epc + 16'd1;
        state_nxt = S_IDLE;
      end
      S_HALT: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed self-checking bench for exception_sequencer.
// Drives on negedge, checks on negedge (mid-cycle).
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exception_flag = 1'b0;
  logic        cause_ovf = 1'b0;
  logic [15:0] pc_in = '0;
  logic [15:0] instr_in = '0;
  logic        eret = 1'b0;
  logic        stall, flush, pc_load, in_handler, halted;
  logic [15:0] pc_target, epc, bad_instr;
  logic [1:0]  cause;
  logic [7:0]  exc_count;

  int n_cmp = 0;
  int n_err = 0;

  // {stall, flush, pc_load, in_handler, halted}
  logic [4:0] ctl;
  assign ctl = {stall, flush, pc_load, in_handler, halted};

  localparam logic [4:0] K_IDLE = 5'b00000;
  localparam logic [4:0] K_FLSH = 5'b11000;
  localparam logic [4:0] K_LOAD = 5'b10100;
  localparam logic [4:0] K_HNDL = 5'b00010;
  localparam logic [4:0] K_HALT = 5'b10001;

  exception_sequencer dut (
    .clk(clk), .rst(rst),
    .exception_flag(exception_flag), .cause_ovf(cause_ovf),
    .pc_in(pc_in), .instr_in(instr_in), .eret(eret),
    .stall(stall), .flush(flush), .pc_load(pc_load),
    .pc_target(pc_target), .epc(epc), .cause(cause),
    .bad_instr(bad_instr), .in_handler(in_handler),
    .halted(halted), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // pulse exception_flag for one edge; returns in the FLUSH cycle
  task automatic fire(input logic ovf, input logic [15:0] pc,
                      input logic [15:0] ins);
    exception_flag = 1'b1;
    cause_ovf = ovf;
    pc_in = pc;
    instr_in = ins;
    step();
    exception_flag = 1'b0;
    cause_ovf = ~ovf;
    pc_in = ~pc;
    instr_in = ~ins;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exception_flag = 1'b1;
    eret = 1'b1;
    step(); step();
    n_cmp++;
    if (ctl !== K_IDLE) begin
      n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, K_IDLE);
    end
    n_cmp++;
    if ({epc, bad_instr, cause, exc_count} !== 42'd0) begin
      n_err++;
      $display("FAIL reset_regs: epc %h bi %h cause %b cnt %h want 0",
               epc, bad_instr, cause, exc_count);
    end
    n_cmp++;
    if (pc_target !== 16'h0000) begin
      n_err++; $display("FAIL reset_tgt: got %h want 0000", pc_target);
    end
    exception_flag = 1'b0;
    eret = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    fire(1'b1, 16'h0042, 16'hABCD);
    n_cmp++;
    if (ctl !== K_FLSH) begin
      n_err++; $display("FAIL ovf_flush: got %b want %b", ctl, K_FLSH);
    end
    n_cmp++;
    if ({epc, cause, exc_count} !== {16'h0042, 2'b10, 8'd1}) begin
      n_err++;
      $display("FAIL ovf_save: epc %h cause %b cnt %h want 0042 10 01",
               epc, cause, exc_count);
    end
    step();
    n_cmp++;
    if ({ctl, pc_target} !== {K_LOAD, 16'h0020}) begin
      n_err++;
      $display("FAIL ovf_vector: ctl %b tgt %h want %b 0020",
               ctl, pc_target, K_LOAD);
    end
    step();
    n_cmp++;
    if (ctl !== K_HNDL) begin
      n_err++; $display("FAIL ovf_handler: got %b want %b", ctl, K_HNDL);
    end
    step();
    n_cmp++;
    if (ctl !== K_HNDL) begin
      n_err++; $display("FAIL ovf_hold: got %b want %b", ctl, K_HNDL);
    end
    eret = 1'b1;
    step();
    eret = 1'b0;
    n_cmp++;
    if ({ctl, pc_target} !== {K_LOAD, 16'h0043}) begin
      n_err++;
      $display("FAIL ovf_return: ctl %b tgt %h want %b 0043",
               ctl, pc_target, K_LOAD);
    end
    step();
  endtask

  task automatic test_illegal_return();
    fire(1'b0, 16'h0100, 16'h1234);
    n_cmp++;
    if ({bad_instr, epc, cause, exc_count} !==
        {16'h1234, 16'h0100, 2'b01, 8'd2}) begin
      n_err++;
      $display("FAIL ill_save: bi %h epc %h cause %b cnt %h want 1234 0100 01 02",
               bad_instr, epc, cause, exc_count);
    end
    step();
    n_cmp++;
    if ({ctl, pc_target} !== {K_LOAD, 16'h0010}) begin
      n_err++;
      $display("FAIL ill_vector: ctl %b tgt %h want %b 0010",
               ctl, pc_target, K_LOAD);
    end
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    n_cmp++;
    if ({ctl, pc_target} !== {K_LOAD, 16'h0101}) begin
      n_err++;
      $display("FAIL ill_return: ctl %b tgt %h want %b 0101",
               ctl, pc_target, K_LOAD);
    end
    step();
    n_cmp++;
    if ({ctl, cause, epc, bad_instr} !==
        {K_IDLE, 2'b00, 16'h0100, 16'h1234}) begin
      n_err++;
      $display("FAIL ill_idle: ctl %b cause %b epc %h bi %h want %b 00 0100 1234",
               ctl, cause, epc, bad_instr, K_IDLE);
    end
  endtask

  task automatic test_wrap();
    fire(1'b0, 16'hFFFF, 16'h0000);
    step(); step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    n_cmp++;
    if ({ctl, pc_target} !== {K_LOAD, 16'h0000}) begin
      n_err++;
      $display("FAIL wrap_return: ctl %b tgt %h want %b 0000",
               ctl, pc_target, K_LOAD);
    end
    step();
    n_cmp++;
    if (exc_count !== 8'd3) begin
      n_err++; $display("FAIL wrap_count: got %h want 03", exc_count);
    end
  endtask

  task automatic test_nested();
    int bad;
    fire(1'b1, 16'h0200, 16'h5555);
    step(); step();
    exception_flag = 1'b1;
    cause_ovf = 1'b0;
    pc_in = 16'h0999;
    eret = 1'b1;
    step();
    exception_flag = 1'b0;
    eret = 1'b0;
    n_cmp++;
    if (ctl !== K_HALT) begin
      n_err++; $display("FAIL nest_halt: got %b want %b", ctl, K_HALT);
    end
    bad = 0;
    for (int i = 0; i < 22; i++) begin
      exception_flag = i[0];
      eret = i[1];
      step();
      if ({ctl, epc, cause, bad_instr, exc_count} !==
          {K_HALT, 16'h0200, 2'b10, 16'h5555, 8'd4}) bad++;
    end
    exception_flag = 1'b0;
    eret = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL nest_sticky: %0d bad cycles, last ctl %b epc %h cause %b cnt %h",
               bad, ctl, epc, cause, exc_count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({ctl, epc, cause, bad_instr, exc_count} !== 47'd0) begin
      n_err++;
      $display("FAIL nest_reset: ctl %b epc %h cause %b cnt %h want 0",
               ctl, epc, cause, exc_count);
    end
  endtask

  task automatic test_ignore();
    eret = 1'b1;
    step();
    eret = 1'b0;
    n_cmp++;
    if ({ctl, exc_count} !== {K_IDLE, 8'd0}) begin
      n_err++;
      $display("FAIL ign_eret_idle: ctl %b cnt %h want %b 00",
               ctl, exc_count, K_IDLE);
    end
    fire(1'b0, 16'h0300, 16'h0001);
    exception_flag = 1'b1;
    step();
    n_cmp++;
    if (ctl !== K_LOAD) begin
      n_err++; $display("FAIL ign_flush: got %b want %b", ctl, K_LOAD);
    end
    step();
    exception_flag = 1'b0;
    n_cmp++;
    if ({ctl, exc_count, epc} !== {K_HNDL, 8'd1, 16'h0300}) begin
      n_err++;
      $display("FAIL ign_vector: ctl %b cnt %h epc %h want %b 01 0300",
               ctl, exc_count, epc, K_HNDL);
    end
    eret = 1'b1;
    step();
    eret = 1'b0;
    exception_flag = 1'b1;
    step();
    exception_flag = 1'b0;
    n_cmp++;
    if ({ctl, exc_count, cause} !== {K_IDLE, 8'd1, 2'b00}) begin
      n_err++;
      $display("FAIL ign_return: ctl %b cnt %h cause %b want %b 01 00",
               ctl, exc_count, cause, K_IDLE);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      fire(1'b1, 16'(i), 16'(i));
      step(); step();
      eret = 1'b1;
      step();
      eret = 1'b0;
      step();
    end
    n_cmp++;
    if ({ctl, exc_count} !== {K_IDLE, 8'hFF}) begin
      n_err++;
      $display("FAIL sat_count: ctl %b cnt %h want %b ff",
               ctl, exc_count, K_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    fire(1'b1, 16'h0777, 16'h0888);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({ctl, exc_count, epc, cause} !== {K_IDLE, 8'd0, 16'h0, 2'b00}) begin
      n_err++;
      $display("FAIL mid_reset: ctl %b cnt %h epc %h cause %b want 0",
               ctl, exc_count, epc, cause);
    end
    step();
    n_cmp++;
    if (ctl !== K_IDLE) begin
      n_err++; $display("FAIL mid_stay: got %b want %b", ctl, K_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_illegal_return();
    test_wrap();
    test_nested();
    test_ignore();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 Parameter VEC_ILLEGAL, default 16'h0010: handler entry address for an illegal-opcode exception.
REQ-002 Parameter VEC_OVF, default 16'h0020: handler entry address for an arithmetic-overflow exception.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port exception_flag, input, 1: exception request from the exception detect logic.
REQ-006 Port cause_ovf, input, 1: qualifies exception_flag; 1 = overflow, 0 = illegal opcode.
REQ-007 Port pc_in, input, 16: PC of the instruction in the faulting stage.
REQ-008 Port instr_in, input, 16: faulting instruction word.
REQ-009 Port eret, input, 1: decoded return-from-exception, one cycle per instruction.
REQ-010 Port stall, output, 1: freeze the pipeline front end.
REQ-011 Port flush, output, 1: squash in-flight instructions.
REQ-012 Port pc_load, output, 1: load pc_target into PC this cycle.
REQ-013 Port pc_target, output, 16: PC redirect value; valid while pc_load=1.
REQ-014 Port epc, output, 16: saved faulting PC.
REQ-015 Port cause, output, 2: 00 none, 01 illegal opcode, 10 overflow; 11 never driven.
REQ-016 Port bad_instr, output, 16: saved faulting instruction.
REQ-017 Port in_handler, output, 1: handler code executing.
REQ-018 Port halted, output, 1: unrecoverable nested exception; sticky until reset.
REQ-019 Port exc_count, output, 8: count of accepted exceptions.

Function
REQ-020 Moore FSM states: IDLE, FLUSH, VECTOR, HANDLER, RETURN, HALT; stall/flush/pc_load/pc_target/in_handler/halted decoded from state only.
REQ-021 IDLE: all control outputs 0; exception_flag=1 sampled at an edge -> FLUSH, and at that same edge epc<=pc_in, bad_instr<=instr_in, cause<=(cause_ovf ? 10 : 01), exc_count+1.
REQ-022 FLUSH (exactly 1 cycle): flush=1, stall=1; -> VECTOR.
REQ-023 VECTOR (exactly 1 cycle): pc_load=1, stall=1, pc_target = VEC_OVF if cause=10 else VEC_ILLEGAL; -> HANDLER.
REQ-024 HANDLER: in_handler=1, stall=0; eret=1 -> RETURN; exception_flag=1 -> HALT; both high at once -> HALT (exception wins).
REQ-025 RETURN (exactly 1 cycle): pc_load=1, stall=1, pc_target = epc+1 modulo 2^16 (16'hFFFF returns to 16'h0000); -> IDLE; cause cleared to 00 on leaving RETURN; epc, bad_instr retained.
REQ-026 HALT: stall=1, halted=1, all other control outputs 0; no exit except rst; epc/cause/bad_instr frozen at first exception values.
REQ-027 Latency: exception sampled at edge N -> flush=1 in cycle N+1, pc_load=1 in N+2, in_handler=1 from N+3.
REQ-028 exception_flag ignored in FLUSH, VECTOR, RETURN; eret ignored in every state except HANDLER.
REQ-029 exc_count increments only on IDLE->FLUSH, saturates at 8'hFF; nested exception (HANDLER->HALT) does not increment.
REQ-030 cause_ovf, pc_in, instr_in sampled only on the accepting edge; changes elsewhere have no effect.

Reset
REQ-031 rst=1 at an edge -> state IDLE, epc=0, bad_instr=0, cause=00, exc_count=0, all control outputs 0; overrides any state including HALT and mid-sequence, and any simultaneous exception_flag/eret.

Verification
REQ-032 Overflow: pc_in=16'h0042, cause_ovf=1, flag 1 cycle -> flush next cycle, pc_load with pc_target=16'h0020 next, epc=16'h0042, cause=10, exc_count=1.
REQ-033 Illegal+return: instr_in=16'h1234, pc_in=16'h0100, cause_ovf=0 -> pc_target=16'h0010, bad_instr=16'h1234; eret in HANDLER -> pc_load, pc_target=16'h0101, then IDLE, cause=00.
REQ-034 Wrap: pc_in=16'hFFFF exception then eret -> return pc_target=16'h0000.
REQ-035 Nested: exception_flag and eret together in HANDLER -> halted=1, stall=1 held 20+ cycles, epc/cause unchanged; rst -> all outputs 0.
REQ-036 Saturation/ignore: 256 exception/eret sequences -> exc_count=8'hFF stays; flag pulsed during FLUSH/VECTOR/RETURN and eret in IDLE -> no state change.
REQ-037 Reset mid-op: rst asserted in VECTOR -> next cycle IDLE, pc_load=0, exc_count=0.
